// File: rtl/uart_word_receiver.sv
// uart_word_receiver: packs bytes from the UART byte receiver into 32-bit
// little-endian words and buffers them in a first-word-fall-through FIFO.
// It also flags framing errors and FIFO overflow, and discards partial words
// that stall for too long.
module uart_word_receiver #(
  parameter int DEPTH       = 8,
  parameter int TIMEOUT_CLK = 100000
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     rx_ready,
  input  logic [7:0]               rdata,
  input  logic                     ferr,
  output logic                     word_valid,
  output logic [31:0]              word_data,
  input  logic                     word_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     frame_err,
  output logic                     timeout
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    ERROR   = 2'd2
  } state_t;

  state_t        state_reg;
  logic [1:0]    idx_reg;
  logic [31:0]   part_reg;
  logic [31:0]   tmo_cnt_reg;
  logic          timeout_reg;
  logic          frame_err_reg;
  logic          overflow_reg;
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [31:0]   mem [DEPTH];

  logic          pop;
  logic          word_done;
  logic          push_ok;
  logic          tmo_expire;
  logic [31:0]   push_word;

  // Head is valid whenever at least one word is stored.
  assign word_valid = (count_reg != '0);
  assign word_data  = word_valid ? mem[rd_ptr_reg] : 32'h0;
  assign count      = count_reg;
  assign overflow   = overflow_reg;
  assign frame_err  = frame_err_reg;
  assign timeout    = timeout_reg;

  assign pop       = word_valid & word_ready;
  // A framing error in the same cycle as the last byte wins: no word is pushed.
  assign word_done = (state_reg == COLLECT) && !ferr && rx_ready && (idx_reg == 2'd3);
  // A full FIFO still accepts the word when the head leaves in the same cycle.
  assign push_ok   = word_done && ((count_reg < CW'(DEPTH)) || pop);
  assign push_word = {rdata, part_reg[23:0]};
  // Expiry happens on the TIMEOUT_CLK-th idle clock; an arriving byte cancels it.
  assign tmo_expire = (TIMEOUT_CLK != 0) && (state_reg == COLLECT) && !ferr && !rx_ready
                      && (tmo_cnt_reg == 32'(TIMEOUT_CLK - 1));

  // Byte collection state machine with idle timeout and sticky framing error.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      idx_reg       <= 2'd0;
      part_reg      <= 32'h0;
      tmo_cnt_reg   <= 32'h0;
      timeout_reg   <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      timeout_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          tmo_cnt_reg <= 32'h0;
          idx_reg     <= 2'd0;
          if (ferr) begin
            state_reg     <= ERROR;
            frame_err_reg <= 1'b1;
          end else if (rx_ready) begin
            part_reg[7:0] <= rdata;
            idx_reg       <= 2'd1;
            state_reg     <= COLLECT;
          end
        end
        COLLECT: begin
          if (ferr) begin
            state_reg     <= ERROR;
            frame_err_reg <= 1'b1;
            idx_reg       <= 2'd0;
            part_reg      <= 32'h0;
            tmo_cnt_reg   <= 32'h0;
          end else if (rx_ready) begin
            tmo_cnt_reg <= 32'h0;
            if (idx_reg == 2'd3) begin
              idx_reg   <= 2'd0;
              state_reg <= IDLE;
            end else begin
              part_reg[{idx_reg, 3'b000} +: 8] <= rdata;
              idx_reg <= idx_reg + 2'd1;
            end
          end else if (tmo_expire) begin
            state_reg   <= IDLE;
            idx_reg     <= 2'd0;
            tmo_cnt_reg <= 32'h0;
            timeout_reg <= 1'b1;
          end else if (TIMEOUT_CLK != 0) begin
            tmo_cnt_reg <= tmo_cnt_reg + 32'd1;
          end
        end
        ERROR: begin
          idx_reg     <= 2'd0;
          tmo_cnt_reg <= 32'h0;
        end
        default: begin
          state_reg <= IDLE;
          idx_reg   <= 2'd0;
        end
      endcase
    end
  end

  // FIFO pointers, occupancy and sticky overflow; full/empty come from the count.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)     rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push_ok, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      if (word_done && !push_ok) overflow_reg <= 1'b1;
    end
  end

  // Word storage; contents need no reset since validity is tracked by the count.
  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr_reg] <= push_word;
  end

endmodule

// File: doc/uart_word_receiver.md
Name: uart_word_receiver

Overview:
- Stage directly downstream of the UART byte receiver.
- Consumes its `rx_ready` pulse, `rdata` byte and `ferr` flag.
- Packs four consecutive bytes, little-endian, into 32-bit words and buffers them in a first-word-fall-through (FWFT) FIFO behind a valid/ready interface (program loader / core input port).
- Flags framing errors, FIFO overflow and stalled partial words.

Parameters:
- DEPTH, 8: FIFO depth in words; power of two, >= 2.
- TIMEOUT_CLK, 100000: idle clocks allowed between bytes of one word before the partial word is discarded; 0 disables the timeout.

Ports:
- clock  in  1  : system clock, rising edge.
- reset_n  in  1  : asynchronous active-low reset.
- rx_ready  in  1  : one-cycle pulse, `rdata` valid.
- rdata  in  8  : received byte.
- ferr  in  1  : framing error level from the UART receiver; stays high until that block is reset.
- word_valid  out  1  : FIFO head valid.
- word_data  out  32  : FIFO head word.
- word_ready  in  1  : consumer accepts the head this cycle.
- count  out  $clog2(DEPTH)+1  : words currently stored.
- overflow  out  1  : sticky; a completed word was dropped because the FIFO was full.
- frame_err  out  1  : sticky; `ferr` was seen.
- timeout  out  1  : one-cycle pulse; a partial word was discarded.

Behaviour:
- Reset (`reset_n` low, async): all of the following are 0: `word_valid`, `word_data`, `count`, `overflow`, `frame_err`, `timeout`, byte index, timeout counter, FIFO pointers. State goes to IDLE.
- Byte packing: byte k of a word (k = 0..3, arrival order) goes to `word_data[8k+7:8k]`.
- States:
  - IDLE: byte index 0. `rx_ready` -> store byte 0, go to COLLECT, index 1.
  - COLLECT: index 1..3.
    - `rx_ready` at index < 3 -> store byte, index+1.
    - `rx_ready` at index 3 -> complete the word, push it, go to IDLE.
  - ERROR: entered from any state on the first cycle `ferr`=1. On entry: `frame_err`<=1, partial word discarded, index<=0. `rx_ready` is ignored. Exit only by reset. FIFO stays drainable in ERROR.
  - `ferr` and `rx_ready` high in the same cycle: `ferr` wins, byte dropped.
- Push:
  - Occurs in the cycle of the 4th `rx_ready`.
  - Accepted if `count` < DEPTH, or `count` == DEPTH with a pop in the same cycle.
  - Otherwise the word is dropped, `overflow`<=1 (sticky), and FIFO contents are unchanged.
- Pop: happens when `word_valid` & `word_ready`. `word_ready` while not valid has no effect.
- `count` update: push only +1; pop only -1; push and pop together, unchanged. Updates on the clock edge after the event.
- Pointers: `log2(DEPTH)` bits, wrap naturally. Full/empty come from `count`, not pointer compare.
- Latency: with the FIFO empty, `word_valid`=1 and `word_data` valid on the cycle after the 4th `rx_ready`.
- Head stability: `word_data` is stable while `word_valid` & !`word_ready`. `word_data` is don't-care while `word_valid`=0.
- Timeout counter:
  - Counts clocks while in COLLECT and no `rx_ready`; cleared on every `rx_ready` and in IDLE/ERROR.
  - When it reaches TIMEOUT_CLK: discard the partial word, go to IDLE, pulse `timeout` for one cycle, clear the counter.
  - `rx_ready` in the expiry cycle: the byte is accepted and no timeout occurs.
  - Counter width: 32 bits.
  - TIMEOUT_CLK=0: counter held at 0, `timeout` never asserts.
- Reset mid-word or mid-drain: everything is cleared immediately (async), stored words are lost, and `word_valid` drops without waiting for a clock.
- No combinational path from `rx_ready`/`rdata` to any output; all outputs are registered, or decoded from registered count/pointers.

Test Plan:
- Bytes 0x78,0x56,0x34,0x12 pulsed 60 clocks apart, `word_ready`=1 -> one cycle after the 4th pulse, `word_valid`=1 and `word_data`=0x12345678; next cycle `count`=0.
- `word_ready`=0, DEPTH=8, 9 words sent -> `count`=8, `overflow`=1 after the 9th word. Draining yields exactly the first 8 words in order, then `word_valid`=0.
- FIFO full, 4th byte pulsed in the same cycle `word_ready`=1 -> no overflow, `count` stays 8, new word read last.
- TIMEOUT_CLK=100: send 2 bytes, then idle 100 clocks -> `timeout` pulses once, then 0xAA,0xBB,0xCC,0xDD -> `word_data`=0xDDCCBBAA. Repeat with a byte arriving exactly on the expiry cycle -> no pulse, byte kept.
- 1 word buffered, 2 bytes in progress, `ferr`=1 -> `frame_err`=1. Buffered word still readable. Later `rx_ready` pulses produce no words. `reset_n` low clears `frame_err`.
- `reset_n` asserted asynchronously with 3 words stored -> `word_valid`, `count`, `overflow` and all other outputs are 0 before the next clock edge.
